// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;
  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int ENTRY_DEF = 32;

  // Index of the highest set bit, -1 when none; used to pick the winning write port.
  function automatic int hi_idx(input logic [31:0] m);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++)
      if (m[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry busy tracking: alloc sets, any write releases, alloc beats release.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int ENTRY   = ENTRY_DEF,
  parameter int NR      = 2,
  parameter int NW      = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
)(
  input  logic                CLK,
  input  logic                RST,
  input  logic [NW-1:0]       WEN,
  input  logic [NW*AW-1:0]    WA,
  input  logic                ALLOC_EN,
  input  logic [AW-1:0]       ALLOC_A,
  input  logic [NR*AW-1:0]    RA,
  output logic [NR-1:0]       RBUSY,
  output logic [ENTRY-1:0]    BUSY_VEC
);
  logic [ENTRY-1:0] busy, rel, al;

  always_comb begin
    rel = '0;
    al  = '0;
    for (int e = 0; e < ENTRY; e++) begin
      for (int i = 0; i < NW; i++)
        if (WEN[i] && WA[i*AW +: AW] == AW'(e)) rel[e] = 1'b1;
      if (ALLOC_EN && ALLOC_A == AW'(e)) al[e] = 1'b1;
    end
    if (ZERO_R0 != 0) begin
      rel[0] = 1'b0;
      al[0]  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) busy <= '0;
    else     busy <= (busy & ~rel) | al;
  end

  assign BUSY_VEC = busy;

  for (genvar j = 0; j < NR; j++) begin : g_rb
    logic [AW-1:0] ra;
    logic          rb;
    assign ra = RA[j*AW +: AW];
    // Out-of-range addresses never match an entry and so read not-busy.
    always_comb begin
      rb = 1'b0;
      for (int e = 0; e < ENTRY; e++)
        if (ra == AW'(e)) rb = busy[e] & ~((BYPASS != 0) & rel[e]);
    end
    assign RBUSY[j] = rb;
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised NR-read / NW-write register file with bypass, zero register and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int ENTRY   = ENTRY_DEF,
  parameter int NR      = 2,
  parameter int NW      = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
)(
  input  logic                CLK,
  input  logic                RST,
  input  logic [NW-1:0]       WEN,
  input  logic [NW*AW-1:0]    WA,
  input  logic [NW*DW-1:0]    DI,
  input  logic [NR*AW-1:0]    RA,
  output logic [NR*DW-1:0]    DOUT,
  output logic [NR-1:0]       RBUSY,
  input  logic                ALLOC_EN,
  input  logic [AW-1:0]       ALLOC_A,
  output logic [ENTRY-1:0]    BUSY_VEC
);
  logic [ENTRY-1:0][DW-1:0] mem;

  // Ports are scanned in ascending order so the highest index lands last.
  always_ff @(posedge CLK) begin
    if (RST) mem <= '0;
    else
      for (int e = 0; e < ENTRY; e++)
        for (int i = 0; i < NW; i++)
          if (WEN[i] && WA[i*AW +: AW] == AW'(e) && !(ZERO_R0 != 0 && e == 0))
            mem[e] <= DI[i*DW +: DW];
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    logic [AW-1:0] ra;
    logic [31:0]   hit;
    logic [DW-1:0] stored, byp, dout;
    logic          in_rng;
    int            sel;

    assign ra     = RA[j*AW +: AW];
    assign in_rng = 32'(ra) < ENTRY;

    always_comb begin
      stored = '0;
      byp    = '0;
      hit    = '0;
      for (int e = 0; e < ENTRY; e++)
        if (ra == AW'(e)) stored = mem[e];
      for (int i = 0; i < NW; i++)
        if (WEN[i] && WA[i*AW +: AW] == ra && in_rng) hit[i] = 1'b1;
      sel = hi_idx(hit);
      for (int i = 0; i < NW; i++)
        if (i == sel) byp = DI[i*DW +: DW];
      if (ZERO_R0 != 0 && ra == '0)   dout = '0;
      else if (BYPASS != 0 && sel >= 0) dout = byp;
      else                              dout = stored;
    end

    assign DOUT[j*DW +: DW] = dout;
  end

  regfile_scoreboard #(
    .AW(AW), .ENTRY(ENTRY), .NR(NR), .NW(NW), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_sb (
    .CLK(CLK), .RST(RST), .WEN(WEN), .WA(WA), .ALLOC_EN(ALLOC_EN), .ALLOC_A(ALLOC_A),
    .RA(RA), .RBUSY(RBUSY), .BUSY_VEC(BUSY_VEC)
  );
endmodule
